// File: rtl/dual_router_pkg.sv
// Shared types and default widths for the dual-output router.
// The optional per-channel word counters are enabled by defining DUAL_ROUTER_COUNT_EN.
package dual_router_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam int DR_WIDTH_DEF     = 8;
  localparam int DR_CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/dual_router_slot.sv
// One-entry output holding slot with a valid/ready handshake.
// A load while FULL is only possible when the consumer drains in the same cycle,
// so the new word simply replaces the old one and the slot stays FULL.
// Optional accepted-word counter is built only when DUAL_ROUTER_COUNT_EN is defined.
module dual_router_slot
  import dual_router_pkg::*;
#(
  parameter int WIDTH     = DR_WIDTH_DEF,
  parameter int CNT_WIDTH = DR_CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_full,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  slot_state_t      r_state;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain = (r_state == FULL) && i_ready;

  // Slot FSM and data register: load wins over drain, data holds while empty
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_load) begin
            r_state <= FULL;
            r_data  <= i_data;
          end
        end
        FULL: begin
          if (i_load) begin
            r_state <= FULL;
            r_data  <= i_data;
          end else if (w_drain) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state == FULL);
  assign o_full  = (r_state == FULL);
  assign o_data  = r_data;

`ifdef DUAL_ROUTER_COUNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  // Count words accepted into this channel, wrapping naturally at all-ones
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
`else
  assign o_cnt = '0;
`endif

endmodule

// File: rtl/dual_output_router.sv
// Single-input, dual-output registered demultiplexer.
// select steers each accepted word into one of two one-entry slots; a stalled
// consumer only blocks the producer while select points at its channel.
// Define DUAL_ROUTER_COUNT_EN to build the per-channel accepted-word counters
// (otherwise cnt0/cnt1 are constant 0).
module dual_output_router
  import dual_router_pkg::*;
#(
  parameter int WIDTH     = DR_WIDTH_DEF,
  parameter int CNT_WIDTH = DR_CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 select,
  output logic                 in_ready,
  output logic                 out0_valid,
  output logic [WIDTH-1:0]     out0_data,
  input  logic                 out0_ready,
  output logic                 out1_valid,
  output logic [WIDTH-1:0]     out1_data,
  input  logic                 out1_ready,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  logic w_full0;
  logic w_full1;
  logic w_sel_full;
  logic w_sel_ready;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // The selected slot can take a word if it is empty or is being drained now
  assign w_sel_full  = select ? w_full1 : w_full0;
  assign w_sel_ready = select ? out1_ready : out0_ready;
  assign in_ready    = !w_sel_full || w_sel_ready;

  assign w_accept = in_valid && in_ready;
  assign w_load0  = w_accept && !select;
  assign w_load1  = w_accept && select;

  dual_router_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot0 (
    .clk     (clk),
    .reset_b (reset_b),
    .i_load  (w_load0),
    .i_data  (in_data),
    .i_ready (out0_ready),
    .o_valid (out0_valid),
    .o_data  (out0_data),
    .o_full  (w_full0),
    .o_cnt   (cnt0)
  );

  dual_router_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot1 (
    .clk     (clk),
    .reset_b (reset_b),
    .i_load  (w_load1),
    .i_data  (in_data),
    .i_ready (out1_ready),
    .o_valid (out1_valid),
    .o_data  (out1_data),
    .o_full  (w_full1),
    .o_cnt   (cnt1)
  );

endmodule

// File: tb/tb_dual_output_router.sv
// Self-checking bench for dual_output_router: a per-channel slot model checked
// every falling edge, plus hand-computed expectations for the directed scenarios.
// Counter expectations follow DUAL_ROUTER_COUNT_EN (constant 0 when undefined).
module tb_dual_output_router;

  localparam int W     = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             reset_b;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             select;
  logic             in_ready;
  logic             out0_valid;
  logic [W-1:0]     out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [W-1:0]     out1_data;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int errorCount = 0;
  int checkCount = 0;

  // Model of the two slots: occupancy, held word and number of accepted words
  bit       mValid [2];
  logic [W-1:0] mData [2];
  int       mCnt   [2];

  dual_output_router #(
    .WIDTH     (W),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .select     (select),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected counter output for a given number of accepted words
  function automatic logic [CNT_W-1:0] expCnt(input int n);
`ifdef DUAL_ROUTER_COUNT_EN
    return CNT_W'(n % (1 << CNT_W));
`else
    return '0;
`endif
  endfunction

  // Expected in_ready from the current inputs and model occupancy
  function automatic bit expReady();
    bit rdy;
    rdy = select ? out1_ready : out0_ready;
    return !mValid[select] || rdy;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each clock edge; async reset discards everything
  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int c = 0; c < 2; c++) begin
        mValid[c] <= 1'b0;
        mData[c]  <= '0;
        mCnt[c]   <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (in_valid && expReady() && (int'(select) == c)) begin
          mValid[c] <= 1'b1;
          mData[c]  <= in_data;
          mCnt[c]   <= mCnt[c] + 1;
        end else if (mValid[c] && ((c == 0) ? out0_ready : out1_ready)) begin
          mValid[c] <= 1'b0;
        end
      end
    end
  end

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    checkOutput("in_ready",   {31'b0, in_ready},   {31'b0, expReady()});
    checkOutput("out0_valid", {31'b0, out0_valid}, {31'b0, mValid[0]});
    checkOutput("out1_valid", {31'b0, out1_valid}, {31'b0, mValid[1]});
    checkOutput("out0_data",  32'(out0_data),      32'(mData[0]));
    checkOutput("out1_data",  32'(out1_data),      32'(mData[1]));
    checkOutput("cnt0",       32'(cnt0),           32'(expCnt(mCnt[0])));
    checkOutput("cnt1",       32'(cnt1),           32'(expCnt(mCnt[1])));
  end

  task automatic applyStimulus(input logic v, input logic sel, input logic [W-1:0] d,
                               input logic r0, input logic r1);
    in_valid   = v;
    select     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_b = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 reset_b = 1'b0;
    #1;
    checkOutput("reset out0_valid", {31'b0, out0_valid}, 32'd0);
    checkOutput("reset out1_valid", {31'b0, out1_valid}, 32'd0);
    checkOutput("reset cnt0", 32'(cnt0), 32'd0);
    tick();
    reset_b = 1'b1;

    // Basic routing of 0xA5 to out0
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    #1 checkOutput("basic in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("basic out0_valid", {31'b0, out0_valid}, 32'd1);
    checkOutput("basic out0_data", 32'(out0_data), 32'hA5);
    checkOutput("basic out1_valid", {31'b0, out1_valid}, 32'd0);
    checkOutput("basic cnt0", 32'(cnt0), 32'(expCnt(1)));

    // Drain out0, then fill out1 with 0x3C and stall it
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    #1 checkOutput("stall in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    checkOutput("stall out1_data", 32'(out1_data), 32'h3C);
    checkOutput("stall out1_valid", {31'b0, out1_valid}, 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    #1 checkOutput("isolate in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    checkOutput("isolate out0_data", 32'(out0_data), 32'h11);
    checkOutput("isolate out0_valid", {31'b0, out0_valid}, 32'd1);

    // Drain both slots
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();

    // Back-to-back stream into out1 with its consumer always ready
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, W'(i), 1'b0, 1'b1);
      #1 checkOutput("stream in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      checkOutput("stream out1_valid", {31'b0, out1_valid}, 32'd1);
      checkOutput("stream out1_data", 32'(out1_data), 32'(i));
    end
    checkOutput("stream cnt1", 32'(cnt1), 32'(expCnt(9)));

    // Drain and load in the same cycle on out0
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h66, 1'b1, 1'b0);
    #1 checkOutput("swap in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    checkOutput("swap out0_valid", {31'b0, out0_valid}, 32'd1);
    checkOutput("swap out0_data", 32'(out0_data), 32'h66);
    checkOutput("swap cnt0", 32'(cnt0), 32'(expCnt(4)));

    // Fill out1 too, then reset mid-cycle with both slots full
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("prereset out0_valid", {31'b0, out0_valid}, 32'd1);
    checkOutput("prereset out1_valid", {31'b0, out1_valid}, 32'd1);
    #1 reset_b = 1'b0;
    #1;
    checkOutput("async out0_valid", {31'b0, out0_valid}, 32'd0);
    checkOutput("async out1_valid", {31'b0, out1_valid}, 32'd0);
    checkOutput("async out0_data", 32'(out0_data), 32'd0);
    checkOutput("async out1_data", 32'(out1_data), 32'd0);
    checkOutput("async cnt0", 32'(cnt0), 32'd0);
    checkOutput("async cnt1", 32'(cnt1), 32'd0);
    tick();
    reset_b = 1'b1;

    // Counter wrap: five words into channel 0 give 1,2,3,0,1 when counting
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b0, W'(8'h20 + k), 1'b1, 1'b0);
      tick();
`ifdef DUAL_ROUTER_COUNT_EN
      checkOutput("wrap cnt0", 32'(cnt0), 32'(k % 4));
`else
      checkOutput("wrap cnt0", 32'(cnt0), 32'd0);
`endif
      checkOutput("wrap out0_data", 32'(out0_data), 32'(8'h20 + k));
    end

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dual_output_router.md
# dual_output_router

Single-input, dual-output registered demultiplexer. It is the opposite direction of the dual-input select flip-flop: one data stream comes in, and `select` chooses which of two registered outputs receives each word. Each output has a one-entry holding slot with a valid/ready handshake, so a stalled consumer blocks only words steered to it. It sits between a single producer and two downstream consumers in the datapath.

## Interface
Parameters:
- `WIDTH`, default 8: data word width.
- `CNT_WIDTH`, default 8: per-channel accepted-word counter width.

Ports:
- `clk` input, 1 bit: single clock, rising-edge.
- `reset_b` input, 1 bit: asynchronous, active-low reset. Asserting it (`reset_b == 0`) clears all state immediately.
- `in_valid` input, 1 bit: the producer offers `in_data`.
- `in_data` input, `WIDTH` bits: offered word.
- `select` input, 1 bit: destination of the offered word (0 = out0, 1 = out1). Must be stable while `in_valid` is high.
- `in_ready` output, 1 bit: the router accepts the offered word this cycle.
- `out0_valid` / `out1_valid` output, 1 bit each: the slot holds a word.
- `out0_data` / `out1_data` output, `WIDTH` bits each: slot contents.
- `out0_ready` / `out1_ready` input, 1 bit each: the consumer takes the word this cycle.
- `cnt0` / `cnt1` output, `CNT_WIDTH` bits each: number of words accepted per channel (see Configuration).

## Operation
- Each output slot is a two-state FSM with states EMPTY and FULL. `outN_valid` is high exactly when the slot is FULL.
- Accept condition: `in_ready = !slot[select].full || outN_ready`, where N = `select`. This is combinational from `select` and that channel's ready.
- Transfer: a word transfers when `in_valid && in_ready` is high at a rising clock edge. The word is written into `slot[select]`.
- Drain: a slot drains when `outN_valid && outN_ready` is high at a rising clock edge.
- Slot transitions:
  - EMPTY → FULL on load.
  - FULL → EMPTY on drain with no load.
  - FULL → FULL on simultaneous drain and load. The new data replaces the old, giving one word per cycle of throughput.
  - Otherwise the slot holds its state.
- Channels are independent. A FULL, stalled out1 never blocks words with `select = 0`. It blocks the producer only while `select = 1`.
- `outN_data` holds its last value while the slot is EMPTY. Data is only meaningful while valid is high.
- Word order is preserved within a channel. No ordering is guaranteed between channels.
- Reset values (asynchronous, on `reset_b` low): all valids 0, all data 0, `cnt0` and `cnt1` 0. Any pending words are discarded, including on reset mid-transfer. The first accept after release is on the first rising edge with `reset_b == 1`.
- If `in_valid` is low, `select` and `in_data` are don't-care and no state changes.

## Timing
- Latency: a word accepted at edge k appears with `outN_valid = 1` after edge k, and is visible in cycle k+1.
- Sustained rate: one word per cycle per channel when the consumer holds ready high.
- `in_ready` has a combinational path from `outN_ready` and `select`. There is no path from `in_valid`.
- All outputs other than `in_ready` are registered.

## Configuration
- Macro: `DUAL_ROUTER_COUNT_EN`.
- Defined:
  - `cnt0` / `cnt1` increment by 1 on each accepted word into that channel.
  - They wrap modulo 2^`CNT_WIDTH` (all-ones + 1 → 0).
  - Reset to 0.
- Undefined:
  - No counter registers are built.
  - `cnt0` and `cnt1` are tied to constant 0.
  - The ports remain, so the interface is identical in both builds.

## Structure
- Package `dual_router_pkg`:
  - Slot state enum `slot_state_t` with values EMPTY and FULL.
  - Default width constants `DR_WIDTH_DEF` = 8 and `DR_CNT_WIDTH_DEF` = 8.
- Sub-module `dual_router_slot`:
  - One instance per channel.
  - Holds that channel's FSM, data register, optional counter, and `load`/`drain` logic.
  - Exposes a `full` flag.
- The top level contains only select decode, `in_ready` generation, and the two slot instances.

## Test plan
- Reset: drive `reset_b` = 0 mid-cycle with both slots FULL → `out0_valid` = `out1_valid` = 0, data = 0, counts = 0 immediately, without a clock edge.
- Basic routing: `in_data` = 0xA5, `select` = 0, `in_valid` for 1 cycle → `out0_valid` = 1 and `out0_data` = 0xA5 the next cycle; `out1_valid` stays 0; `cnt0` = 1.
- Backpressure isolation: out1 FULL with 0x3C and `out1_ready` = 0; offer 0x11 with `select` = 1 → `in_ready` = 0 and out1 holds 0x3C. Switch to `select` = 0 → `in_ready` = 1 and 0x11 lands in out0.
- Full throughput: `out1_ready` = 1 held, stream 0x01..0x08 with `select` = 1 back-to-back → `in_ready` stays 1, and out1 presents 0x01..0x08 on 8 consecutive cycles, each one cycle after acceptance.
- Counter wrap (`DUAL_ROUTER_COUNT_EN` defined, `CNT_WIDTH` = 2): 5 words to channel 0 → `cnt0` sequence 1, 2, 3, 0, 1. Without the macro, `cnt0` = 0 throughout.
- Drain and load in the same cycle: out0 FULL with 0x55, `out0_ready` = 1, offer 0x66 with `select` = 0 → `in_ready` = 1; next cycle `out0_valid` = 1 and `out0_data` = 0x66, with no bubble.
